// File: rtl/uart_tx_dev.sv
// Memory-mapped 8N1 UART transmitter: TX FIFO, baud-divided serialiser, drain IRQ.
// Define UART_TX_PARITY_EN to add an optional parity bit (CTRL[2]=PEN, CTRL[3]=ODD).
module uart_tx_dev #(
  parameter int               FIFO_DEPTH = 4,
  parameter int               DIV_W      = 16,
  parameter logic [DIV_W-1:0] DIV_RESET  = 16'd868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:2]  Addr,
  input  logic        WE,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  output logic        IRQ,
  output logic        TxD
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  // Counter reload for one bit: max(div,1)-1, so DIV=0 behaves like DIV=1.
  function automatic logic [DIV_W-1:0] bit_reload(input logic [DIV_W-1:0] div);
    return (div == '0) ? '0 : div - 1'b1;
  endfunction

  logic [DIV_W-1:0] div_q;
  logic             txen;
  logic             ie;
`ifdef UART_TX_PARITY_EN
  logic             pen;
  logic             odd;
`endif
  logic             ovf;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_d;
  logic             empty;
  logic             full;
  logic             push_req;
  logic             push_ok;
  logic             pop;

  state_t           state;
  state_t           state_d;
  logic [DIV_W-1:0] baud_cnt;
  logic [DIV_W-1:0] cnt_d;
  logic [DIV_W-1:0] cnt_dec;
  logic [DIV_W-1:0] reload;
  logic             bit_end;
  logic [2:0]       bit_idx;
  logic [2:0]       idx_d;
  logic [7:0]       shift;
  logic [7:0]       shift_d;
  logic             txd_d;
  logic             txd_p1;
  logic             irq_p1;
  logic             busy;
  logic [7:0]       cnt8;
  logic [31:0]      ctrl_rd;
  logic             unused_wd;

  assign unused_wd = ^WD;

  assign empty    = (count == '0);
  assign full     = (count == CW'(FIFO_DEPTH));
  assign busy     = (state != S_IDLE);
  assign cnt8     = 8'(count);
  assign reload   = bit_reload(div_q);
  assign bit_end  = (baud_cnt == '0);
  assign cnt_dec  = baud_cnt - 1'b1;

  // A push into a full FIFO still lands when the serialiser pops the same cycle.
  assign push_req = WE && (Addr == 2'd0);
  assign push_ok  = push_req && (!full || pop);

  always_comb begin
    count_d = count;
    unique case ({push_ok, pop})
      2'b10:   count_d = count + 1'b1;
      2'b01:   count_d = count - 1'b1;
      default: count_d = count;
    endcase
  end

  always_comb begin
    state_d = state;
    cnt_d   = baud_cnt;
    idx_d   = bit_idx;
    shift_d = shift;
    pop     = 1'b0;
    unique case (state)
      S_IDLE: begin
        cnt_d = '0;
        if (txen && !empty) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr];
          state_d = S_START;
          cnt_d   = reload;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          idx_d   = '0;
          cnt_d   = reload;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d = reload;
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = pen ? S_PARITY : S_STOP;
`else
            state_d = S_STOP;
`endif
          end else begin
            idx_d = bit_idx + 1'b1;
          end
        end else begin
          cnt_d = cnt_dec;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          cnt_d   = reload;
        end else begin
          cnt_d = cnt_dec;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          // Chain straight into the next START when more data is waiting.
          if (txen && !empty) begin
            pop     = 1'b1;
            shift_d = mem[rd_ptr];
            state_d = S_START;
            cnt_d   = reload;
          end else begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_dec;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    txd_d = 1'b1;
    unique case (state_d)
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = shift_d[idx_d];
`ifdef UART_TX_PARITY_EN
      S_PARITY: txd_d = (^shift_d) ^ odd;
`endif
      default:  txd_d = 1'b1;
    endcase
  end

  // ---- stage p1: control state and registered line outputs ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q    <= DIV_RESET;
      txen     <= 1'b0;
      ie       <= 1'b0;
`ifdef UART_TX_PARITY_EN
      pen      <= 1'b0;
      odd      <= 1'b0;
`endif
      ovf      <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      txd_p1   <= 1'b1;
      irq_p1   <= 1'b0;
    end else begin
      if (WE && (Addr == 2'd2)) div_q <= WD[DIV_W-1:0];
      if (WE && (Addr == 2'd3)) begin
        txen <= WD[0];
        ie   <= WD[1];
`ifdef UART_TX_PARITY_EN
        pen  <= WD[2];
        odd  <= WD[3];
`endif
      end
      if (WE && (Addr == 2'd1))      ovf <= 1'b0;
      else if (push_req && !push_ok) ovf <= 1'b1;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      count    <= count_d;
      state    <= state_d;
      baud_cnt <= cnt_d;
      bit_idx  <= idx_d;
      txd_p1   <= txd_d;
      irq_p1   <= ie && empty && (state == S_IDLE);
    end
  end

  // ---- stage p1: data storage, no reset needed ----
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= WD[7:0];
    shift <= shift_d;
  end

  assign TxD = txd_p1;
  assign IRQ = irq_p1;

`ifdef UART_TX_PARITY_EN
  assign ctrl_rd = {28'b0, odd, pen, ie, txen};
`else
  assign ctrl_rd = {30'b0, ie, txen};
`endif

  always_comb begin
    RD = '0;
    unique case (Addr)
      2'd0:    RD = '0;
      2'd1:    RD = {16'b0, cnt8, 4'b0, ovf, empty, full, busy};
      2'd2:    RD = 32'(div_q);
      default: RD = ctrl_rd;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_dev.sv
// Self-checking bench for uart_tx_dev: directed register/timing steps plus random frames
// checked against a frame-level model (bit vector per byte, queue for the FIFO).
module tb_uart_tx_dev;
  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic [1:0]  Addr;
  logic        WE;
  logic [31:0] WD;
  logic [31:0] RD;
  logic        IRQ;
  logic        TxD;

  int n_cmp = 0;
  int n_bad = 0;

  uart_tx_dev dut (
    .clk(clk), .reset(reset), .Addr(Addr), .WE(WE), .WD(WD),
    .RD(RD), .IRQ(IRQ), .TxD(TxD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_status(input int cnt, input bit ovf, input bit busy);
    return {16'b0, 8'(cnt), 4'b0, ovf, (cnt == 0), (cnt == DEPTH), busy};
  endfunction

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    Addr = a; WD = d; WE = 1'b1;
    @(negedge clk);
    WE = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    Addr = a; WE = 1'b0;
    #1 v = RD;
  endtask

  // Watches one frame starting at the current cycle; each bit must hold for exactly d cycles.
  // Optional DATA writes at frame cycle 2 and at the last cycle of the frame.
  task automatic check_frame(input logic [7:0] b, input int d, input bit par, input bit odd,
                             input bit chk_irq, input bit push_mid, input logic [7:0] mid_b,
                             input bit push_end, input logic [7:0] end_b);
    logic [10:0] fr;
    int nbits;
    int total;
    int cyc;
    int irq_bad;
    nbits = par ? 11 : 10;
    fr = par ? {1'b1, (^b) ^ odd, b, 1'b0} : {1'b0, 1'b1, b, 1'b0};
    total = nbits * d;
    cyc = 0;
    irq_bad = 0;
    for (int i = 0; i < nbits; i++) begin
      int bad;
      bad = 0;
      for (int c = 0; c < d; c++) begin
        #1;
        if (TxD !== fr[i]) bad++;
        if (chk_irq && IRQ !== 1'b0) irq_bad++;
        if (push_mid && cyc == 2) begin
          Addr = 2'd0; WD = {24'b0, mid_b}; WE = 1'b1;
        end else if (push_end && cyc == total - 1) begin
          Addr = 2'd0; WD = {24'b0, end_b}; WE = 1'b1;
        end else begin
          WE = 1'b0;
        end
        cyc++;
        @(negedge clk);
      end
      chk($sformatf("frame_%02h_bit%0d_bad_cycles", b, i), bad, 0);
    end
    WE = 1'b0;
    if (chk_irq) chk("irq_low_during_frame", irq_bad, 0);
  endtask

  initial begin
    logic [31:0] v;
    logic [7:0]  q[$];
    logic [7:0]  bs[5];
    logic [7:0]  cur;
    logic [7:0]  p;
    logic [7:0]  qb;
    int          d;
    int          n;
    int          hi_bad;
    bit          ovf_m;

    reset = 1'b1; Addr = '0; WE = 1'b0; WD = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state
    rd(2'd1, v); chk("rst_status", v, 32'h0000_0004);
    rd(2'd2, v); chk("rst_div", v, 32'd868);
    @(negedge clk);
    rd(2'd3, v); chk("rst_ctrl", v, 32'h0);
    rd(2'd0, v); chk("rst_data", v, 32'h0);
    chk("rst_txd", TxD, 1);
    chk("rst_irq", IRQ, 0);
    @(negedge clk);

    // Single frame 0xA5 at D=4
    wr(2'd2, 4); wr(2'd3, 1); wr(2'd0, 32'hA5);
    chk("txd_before_pop", TxD, 1);
    @(negedge clk);
    chk("txd_fall", TxD, 0);
    check_frame(8'hA5, 4, 0, 0, 0, 0, 8'h0, 0, 8'h0);
    rd(2'd1, v); chk("a5_idle_status", v, exp_status(0, 0, 0));
    @(negedge clk);

    // Overflow, OVF clear, back-to-back frames, full-FIFO push on the STOP->START pop
    wr(2'd2, 2); wr(2'd3, 0);
    q.delete();
    for (int i = 0; i < 5; i++) begin
      bs[i] = 8'($urandom);
      wr(2'd0, {24'b0, bs[i]});
      if (q.size() < DEPTH) q.push_back(bs[i]);
    end
    rd(2'd1, v); chk("ovf_status", v, 32'h0000_040A);
    wr(2'd1, 0);
    rd(2'd1, v); chk("ovf_cleared", v, 32'h0000_0402);
    wr(2'd3, 1);
    @(negedge clk);
    p  = 8'($urandom);
    qb = 8'($urandom);
    cur = q.pop_front();
    check_frame(cur, 2, 0, 0, 0, 1, p, 1, qb);
    q.push_back(p);
    q.push_back(qb);
    cur = q.pop_front();
    rd(2'd1, v); chk("full_push_on_pop", v, exp_status(q.size(), 0, 1));
    check_frame(cur, 2, 0, 0, 0, 0, 8'h0, 0, 8'h0);
    while (q.size() > 0) begin
      cur = q.pop_front();
      check_frame(cur, 2, 0, 0, 0, 0, 8'h0, 0, 8'h0);
    end
    rd(2'd1, v); chk("b2b_drained", v, exp_status(0, 0, 0));
    @(negedge clk);

    // IRQ behaviour at D=1
    wr(2'd2, 1); wr(2'd3, 0);
    cur = 8'($urandom);
    wr(2'd0, {24'b0, cur});
    wr(2'd3, 3);
    chk("irq_pending_data", IRQ, 0);
    @(negedge clk);
    check_frame(cur, 1, 0, 0, 1, 0, 8'h0, 0, 8'h0);
    chk("irq_lag_at_idle", IRQ, 0);
    @(negedge clk);
    chk("irq_raised", IRQ, 1);
    cur = 8'($urandom);
    wr(2'd0, {24'b0, cur});
    chk("irq_hold_one_cycle", IRQ, 1);
    @(negedge clk);
    chk("irq_dropped", IRQ, 0);
    check_frame(cur, 1, 0, 0, 1, 0, 8'h0, 0, 8'h0);
    wr(2'd3, 1);

    // Random divisors (including 0 -> 1) and random burst lengths
    for (int it = 0; it < 5; it++) begin
      logic [31:0] dv;
      dv = $urandom_range(0, 3);
      d = (dv == 0) ? 1 : int'(dv);
      wr(2'd3, 0); wr(2'd2, dv);
      n = $urandom_range(1, 6);
      ovf_m = 1'b0;
      for (int j = 0; j < n; j++) begin
        cur = 8'($urandom);
        wr(2'd0, {24'b0, cur});
        if (q.size() < DEPTH) q.push_back(cur); else ovf_m = 1'b1;
      end
      rd(2'd1, v); chk("rnd_status", v, exp_status(q.size(), ovf_m, 0));
      wr(2'd1, 0);
      rd(2'd1, v); chk("rnd_ovf_clr", v, exp_status(q.size(), 0, 0));
      wr(2'd3, 1);
      @(negedge clk);
      while (q.size() > 0) begin
        cur = q.pop_front();
        check_frame(cur, d, 0, 0, 0, 0, 8'h0, 0, 8'h0);
      end
      rd(2'd1, v); chk("rnd_idle", v, exp_status(0, 0, 0));
      @(negedge clk);
    end

`ifdef UART_TX_PARITY_EN
    wr(2'd2, 2); wr(2'd3, 5);
    rd(2'd3, v); chk("ctrl_pen", v, 32'h5);
    wr(2'd0, 32'h07);
    @(negedge clk);
    check_frame(8'h07, 2, 1, 0, 0, 0, 8'h0, 0, 8'h0);
    wr(2'd3, 32'hD);
    rd(2'd3, v); chk("ctrl_pen_odd", v, 32'hD);
    cur = 8'($urandom);
    wr(2'd0, {24'b0, cur});
    @(negedge clk);
    check_frame(cur, 2, 1, 1, 0, 0, 8'h0, 0, 8'h0);
    rd(2'd1, v); chk("parity_idle", v, exp_status(0, 0, 0));
    wr(2'd3, 0);
`else
    wr(2'd3, 32'hF);
    rd(2'd3, v); chk("ctrl_upper_ignored", v, 32'h3);
    wr(2'd3, 0);
`endif

    // Asynchronous reset during DATA bit 3
    wr(2'd2, 4);
    wr(2'd0, 32'h00);
    wr(2'd0, 32'h3C);
    wr(2'd3, 1);
    @(negedge clk);
    repeat (17) @(negedge clk);
    chk("txd_in_bit3", TxD, 0);
    #1 reset = 1'b1;
    #1 chk("txd_async_reset", TxD, 1);
    @(negedge clk);
    reset = 1'b0;
    rd(2'd1, v); chk("post_reset_status", v, 32'h0000_0004);
    rd(2'd3, v); chk("post_reset_ctrl", v, 32'h0);
    @(negedge clk);
    wr(2'd3, 1);
    hi_bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (TxD !== 1'b1) hi_bad++;
      @(negedge clk);
    end
    chk("no_frame_after_reset", hi_bad, 0);
    rd(2'd1, v); chk("fifo_lost", v, 32'h0000_0004);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
